// File: rtl/piso_word_transmitter.sv
// Parallel-in/serial-out word transmitter, LSB first, one bit per clock after a valid/ready load.
// Optional forced idle gap between words; zero gap allows contiguous back-to-back words.
module piso_word_transmitter #(
  parameter int   DATA_WIDTH = 32,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                            Clk_In,
  input  logic                            Reset_In,
  input  logic [DATA_WIDTH-1:0]           Load_Data_In,
  input  logic                            Load_Valid_In,
  output logic                            Load_Ready_Out,
  output logic                            Serial_Data_Out,
  output logic                            Shift_Enable_Out,
  output logic                            Frame_Done_Out,
  output logic                            Busy_Out,
  output logic [$clog2(DATA_WIDTH+1)-1:0] Bit_Count_Out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [GW-1:0]         gap_cnt;
  logic                  transfer;

  assign transfer = Load_Valid_In & Load_Ready_Out;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state            <= IDLE;
      shift_reg        <= '0;
      gap_cnt          <= '0;
      Serial_Data_Out  <= IDLE_LEVEL;
      Load_Ready_Out   <= 1'b1;
      Shift_Enable_Out <= 1'b0;
      Frame_Done_Out   <= 1'b0;
      Busy_Out         <= 1'b0;
      Bit_Count_Out    <= '0;
    end else begin
      Frame_Done_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            Serial_Data_Out  <= Load_Data_In[0];
            shift_reg        <= Load_Data_In >> 1;
            Bit_Count_Out    <= CW'(1);
            Shift_Enable_Out <= 1'b1;
            Busy_Out         <= 1'b1;
            Load_Ready_Out   <= 1'b0;
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          if (Bit_Count_Out != LAST) begin
            Serial_Data_Out <= shift_reg[0];
            shift_reg       <= shift_reg >> 1;
            Bit_Count_Out   <= Bit_Count_Out + 1'b1;
            Frame_Done_Out  <= (Bit_Count_Out == LAST - 1'b1);
            // With no gap, the last bit cycle also accepts the next word.
            Load_Ready_Out  <= (GAP_CYCLES == 0) && (Bit_Count_Out == LAST - 1'b1);
          end else if (transfer) begin
            Serial_Data_Out  <= Load_Data_In[0];
            shift_reg        <= Load_Data_In >> 1;
            Bit_Count_Out    <= CW'(1);
            Load_Ready_Out   <= 1'b0;
          end else begin
            Serial_Data_Out  <= IDLE_LEVEL;
            Bit_Count_Out    <= '0;
            Shift_Enable_Out <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt        <= GW'(GAP_CYCLES);
              Load_Ready_Out <= 1'b0;
              state          <= GAP;
            end else begin
              Busy_Out       <= 1'b0;
              Load_Ready_Out <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(1)) begin
            gap_cnt        <= '0;
            Busy_Out       <= 1'b0;
            Load_Ready_Out <= 1'b1;
            state          <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_word_transmitter.sv
// Bench for piso_word_transmitter: two instances (no gap / low idle, 3-cycle gap / high idle)
// checked every cycle against a timeline model plus a chained SISO receiver.
module tb_piso_word_transmitter;

  localparam int W = 32;
  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [31:0] dat0, dat1;
  logic [1:0]  rdy, line, sen, done, busy;
  logic [5:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  piso_word_transmitter #(.DATA_WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u0 (
    .Clk_In(clk), .Reset_In(rst), .Load_Data_In(dat0), .Load_Valid_In(vld[0]),
    .Load_Ready_Out(rdy[0]), .Serial_Data_Out(line[0]), .Shift_Enable_Out(sen[0]),
    .Frame_Done_Out(done[0]), .Busy_Out(busy[0]), .Bit_Count_Out(cnt0)
  );

  piso_word_transmitter #(.DATA_WIDTH(W), .GAP_CYCLES(3), .IDLE_LEVEL(1'b1)) u1 (
    .Clk_In(clk), .Reset_In(rst), .Load_Data_In(dat1), .Load_Valid_In(vld[1]),
    .Load_Ready_Out(rdy[1]), .Serial_Data_Out(line[1]), .Shift_Enable_Out(sen[1]),
    .Frame_Done_Out(done[1]), .Busy_Out(busy[1]), .Bit_Count_Out(cnt1)
  );

  // Expected outputs per instance per cycle; cycle t is the interval after posedge t.
  logic        e_line [2][N];
  logic        e_sen  [2][N];
  logic        e_done [2][N];
  logic        e_busy [2][N];
  logic [5:0]  e_cnt  [2][N];
  int          busy_until [2];
  int          last_bit   [2];
  int          gapv  [2] = '{0, 3};
  logic        idlev [2] = '{1'b0, 1'b1};
  logic [31:0] wq0[$], wq1[$];
  logic [31:0] siso [2];
  logic        acc  [2];
  int          cyc, n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit model_ready(input int d, input int t);
    return (t > busy_until[d]) || (gapv[d] == 0 && t == last_bit[d]);
  endfunction

  task automatic model_clear(input int d, input int from);
    for (int t = from; t < N; t++) begin
      e_line[d][t] = idlev[d];
      e_sen[d][t]  = 1'b0;
      e_done[d][t] = 1'b0;
      e_busy[d][t] = 1'b0;
      e_cnt[d][t]  = '0;
    end
    busy_until[d] = -1;
    last_bit[d]   = -1;
    if (d == 0) wq0.delete(); else wq1.delete();
  endtask

  // A word accepted at posedge k puts bit i on the line in cycle k+i, then gapv idle-level busy cycles.
  task automatic schedule(input int d, input int k, input logic [31:0] w);
    for (int i = 0; i < W; i++) begin
      e_line[d][k+i] = w[i];
      e_sen[d][k+i]  = 1'b1;
      e_done[d][k+i] = (i == W - 1);
      e_busy[d][k+i] = 1'b1;
      e_cnt[d][k+i]  = 6'(i + 1);
    end
    for (int g = 0; g < gapv[d]; g++) e_busy[d][k+W+g] = 1'b1;
    last_bit[d]   = k + W - 1;
    busy_until[d] = k + W - 1 + gapv[d];
    if (d == 0) wq0.push_back(w); else wq1.push_back(w);
  endtask

  task automatic check_cycle(input int d);
    logic [5:0]  oc;
    logic [31:0] expw;
    oc = (d == 0) ? cnt0 : cnt1;
    chk($sformatf("u%0d.line@%0d", d, cyc), line[d], e_line[d][cyc]);
    chk($sformatf("u%0d.shift_en@%0d", d, cyc), sen[d], e_sen[d][cyc]);
    chk($sformatf("u%0d.done@%0d", d, cyc), done[d], e_done[d][cyc]);
    chk($sformatf("u%0d.busy@%0d", d, cyc), busy[d], e_busy[d][cyc]);
    chk($sformatf("u%0d.bit_count@%0d", d, cyc), oc, e_cnt[d][cyc]);
    chk($sformatf("u%0d.ready@%0d", d, cyc), rdy[d], model_ready(d, cyc));
    // Receiver shifts on negedge, MSB in; holds the word right after the last bit's negedge.
    siso[d] = {line[d], siso[d][31:1]};
    if (e_done[d][cyc]) begin
      if (d == 0) expw = (wq0.size() > 0) ? wq0.pop_front() : 32'hx;
      else        expw = (wq1.size() > 0) ? wq1.pop_front() : 32'hx;
      chk($sformatf("u%0d.siso_word@%0d", d, cyc), siso[d], expw);
    end
  endtask

  task automatic tick();
    logic        an [2];
    logic [31:0] dw [2];
    dw[0] = dat0;
    dw[1] = dat1;
    for (int d = 0; d < 2; d++) an[d] = vld[d] && !rst && model_ready(d, cyc);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      acc[d] = an[d];
      if (an[d]) schedule(d, cyc, dw[d]);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_cycle(d);
  endtask

  task automatic send(input int d, input logic [31:0] w, output int k);
    if (d == 0) dat0 = w; else dat1 = w;
    vld[d] = 1'b1;
    k = -1;
    for (int i = 0; i < 200 && k < 0; i++) begin
      tick();
      if (acc[d]) k = cyc;
    end
    vld[d] = 1'b0;
    chk($sformatf("u%0d.accept_within_bound", d), 32'(k >= 0), 32'd1);
  endtask

  task automatic check_reset_values(input int d);
    logic [5:0] oc;
    oc = (d == 0) ? cnt0 : cnt1;
    chk($sformatf("u%0d.rst_line", d), line[d], idlev[d]);
    chk($sformatf("u%0d.rst_ready", d), rdy[d], 1'b1);
    chk($sformatf("u%0d.rst_shift_en", d), sen[d], 1'b0);
    chk($sformatf("u%0d.rst_done", d), done[d], 1'b0);
    chk($sformatf("u%0d.rst_busy", d), busy[d], 1'b0);
    chk($sformatf("u%0d.rst_bit_count", d), oc, 6'd0);
  endtask

  initial begin
    int k1, k2, lows;
    rst = 1'b1; vld = '0; dat0 = '0; dat1 = '0;
    cyc = 0; n_cmp = 0; n_err = 0;
    acc[0] = 1'b0; acc[1] = 1'b0; siso[0] = '0; siso[1] = '0;
    model_clear(0, 0);
    model_clear(1, 0);
    #1;
    check_reset_values(0);
    check_reset_values(1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single word, no gap.
    send(0, 32'hA5A5_0F01, k1);
    repeat (40) tick();

    // Back-to-back words with valid held: contiguous.
    send(0, 32'hFFFF_0000, k1);
    send(0, 32'h0000_FFFF, k2);
    chk("b2b_spacing", 32'(k2 - k1), 32'd32);
    repeat (40) tick();

    // Gap instance: second word waits out the gap plus the idle cycle.
    send(1, 32'h1234_5678, k1);
    send(1, 32'h8765_4321, k2);
    chk("gap_spacing", 32'(k2 - k1), 32'(W + 3 + 1));
    repeat (45) tick();

    // Data changes after acceptance and a mid-word request are ignored until the word ends.
    send(0, 32'h0F0F_3C3C, k1);
    for (int i = 0; i < 10; i++) begin
      dat0 = $urandom;
      tick();
    end
    send(0, 32'hDEAD_BEEF, k2);
    chk("midword_req_spacing", 32'(k2 - k1), 32'd32);
    repeat (40) tick();

    // Reset while bit 17 is on the line.
    send(0, 32'hC3C3_5AA5, k1);
    repeat (16) tick();
    chk("bit17_count", cnt0, 6'd17);
    #1 rst = 1'b1;
    model_clear(0, cyc);
    model_clear(1, cyc);
    #1;
    check_reset_values(0);
    check_reset_values(1);
    tick();
    rst = 1'b0;
    tick();
    send(0, 32'h1357_9BDF, k1);
    repeat (40) tick();

    // High idle level: all-zero word yields exactly 32 low cycles.
    send(1, 32'h0000_0000, k1);
    lows = (line[1] == 1'b0) ? 1 : 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (line[1] == 1'b0) lows++;
    end
    chk("idle_high_zero_word_lows", 32'(lows), 32'd32);

    // Randomized traffic on both instances; source holds each word until accepted.
    for (int i = 0; i < 2500; i++) begin
      if (!vld[0] || acc[0]) begin
        vld[0] = ($urandom_range(0, 2) == 0);
        dat0   = $urandom;
      end
      if (!vld[1] || acc[1]) begin
        vld[1] = ($urandom_range(0, 2) == 0);
        dat1   = $urandom;
      end
      tick();
    end
    vld = '0;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
